ccff_chain_loader: RTL

CCFF_CHAIN_LOADER -- requirements
Module: ccff_chain_loader

---
 rtl/ccff_pkg.sv | 17 +
 rtl/ccff_rb_packer.sv | 51 +++++
 rtl/ccff_chain_loader.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/ccff_pkg.sv
// Shared types and constants for the configuration-chain loader.
// Holds the FSM state enum, byte width and default isolation length.
package ccff_pkg;

  localparam int BYTE_W       = 8;
  localparam int BIT_W        = $clog2(BYTE_W);
  localparam int ISOL_CYC_DEF = 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISOL,
    S_FETCH,
    S_SHIFT,
    S_RELEASE
  } state_t;

endpackage

// File: rtl/ccff_rb_packer.sv
// Serial-to-byte packer for bits displaced out of the chain tail.
// Ports: clk/rst_n, i_en (sample strobe), i_bit, i_last (final sample),
//        o_data (packed byte, LSB = first bit), o_valid (1-cycle strobe).
module ccff_rb_packer
  import ccff_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_en,
  input  logic              i_bit,
  input  logic              i_last,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid
);

  logic [BYTE_W-1:0] r_sr;
  logic [BIT_W-1:0]  r_n;
  logic [BYTE_W-1:0] r_data;
  logic              r_valid;
  logic [BYTE_W-1:0] w_word;
  logic              w_flush;

  assign w_word  = r_sr | (BYTE_W'(i_bit) << r_n);
  assign w_flush = (r_n == BIT_W'(BYTE_W - 1)) || i_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sr    <= '0;
      r_n     <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (i_en) begin
        if (w_flush) begin
          r_data  <= w_word;
          r_valid <= 1'b1;
          r_sr    <= '0;
          r_n     <= '0;
        end else begin
          r_sr <= w_word;
          r_n  <= r_n + 1'b1;
        end
      end
    end
  end

  assign o_data  = r_data;
  assign o_valid = r_valid;

endmodule

// File: rtl/ccff_chain_loader.sv
// Streams a byte bitstream LSB-first into a CCFF configuration chain,
// keeping fabric IO isolated for the whole load.
// Ports: prog_clk/prog_reset_n, cfg_start, in_data/in_valid/in_ready,
//        ccff_head/ccff_tail, prog_clk_en, IO_ISOL_N, cfg_busy, cfg_done,
//        rb_data/rb_valid (only with CCFF_READBACK_EN defined).
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int ISOL_CYC  = ISOL_CYC_DEF
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              cfg_start,
  input  logic [BYTE_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              prog_clk_en,
`ifdef CCFF_READBACK_EN
  output logic [BYTE_W-1:0] rb_data,
  output logic              rb_valid,
`endif
  output logic              IO_ISOL_N,
  output logic              cfg_busy,
  output logic              cfg_done
);

  localparam int CW = $clog2(CHAIN_LEN + 1);
  localparam int IW = (ISOL_CYC > 1) ? $clog2(ISOL_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(CHAIN_LEN - 1);
  localparam logic [IW-1:0] ISOL_LAST =
    IW'((ISOL_CYC > 0) ? ISOL_CYC - 1 : 0);

  state_t            r_state;
  state_t            w_next;
  logic [BYTE_W-1:0] r_byte;
  logic [BIT_W-1:0]  r_bitn;
  logic [CW-1:0]     r_cnt;
  logic [IW-1:0]     r_isol;
  logic              r_iso_n;
  logic              r_busy;
  logic              r_done;

  logic w_last;
  logic w_byte_end;
  logic w_en;
  logic w_rdy;

  assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_LAST);
  assign w_byte_end = (r_bitn == BIT_W'(BYTE_W - 1));

  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) r_state <= S_IDLE;
    else               r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (cfg_start) w_next = S_ISOL;
      S_ISOL:    if (r_isol == ISOL_LAST) w_next = S_FETCH;
      S_FETCH:   if (in_valid) w_next = S_SHIFT;
      S_SHIFT: begin
        if (w_last)          w_next = S_RELEASE;
        else if (w_byte_end) w_next = S_FETCH;
      end
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_en  = 1'b0;
    w_rdy = 1'b0;
    unique case (1'b1)
      (r_state == S_SHIFT): w_en  = 1'b1;
      (r_state == S_FETCH): w_rdy = 1'b1;
      default: ;
    endcase
  end

  // The byte register is not shifted on its last bit so the head
  // holds steady while FETCH waits for the next byte.
  always_ff @(posedge prog_clk or negedge prog_reset_n) begin
    if (!prog_reset_n) begin
      r_byte  <= '0;
      r_bitn  <= '0;
      r_cnt   <= '0;
      r_isol  <= '0;
      r_iso_n <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cfg_start) begin
            r_iso_n <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_isol  <= '0;
          end
        end
        S_ISOL: r_isol <= r_isol + 1'b1;
        S_FETCH: begin
          if (in_valid) begin
            r_byte <= in_data;
            r_bitn <= '0;
          end
        end
        S_SHIFT: begin
          r_cnt  <= r_cnt + 1'b1;
          r_bitn <= r_bitn + 1'b1;
          if (!w_byte_end) r_byte <= r_byte >> 1;
          if (w_last) begin
            r_iso_n <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = w_rdy;
  assign prog_clk_en = w_en;
  assign ccff_head   = r_byte[0];
  assign IO_ISOL_N   = r_iso_n;
  assign cfg_busy    = r_busy;
  assign cfg_done    = r_done;

`ifdef CCFF_READBACK_EN
  ccff_rb_packer u_rb (
    .clk     (prog_clk),
    .rst_n   (prog_reset_n),
    .i_en    (w_en),
    .i_bit   (ccff_tail),
    .i_last  (w_last),
    .o_data  (rb_data),
    .o_valid (rb_valid)
  );
`else
  logic w_unused;
  assign w_unused = ccff_tail;
`endif

endmodule
